// File: rtl/attack_if.sv
// Board-side signal bundle for attack_enable_ctrl: button, unit select, mode and reload in;
// gated enables, type strobes and status out.
interface attack_if #(
  parameter int N_UNITS   = 3,
  parameter int MAX_SHOTS = 5
);
  localparam int SHOT_W = $clog2(MAX_SHOTS + 1);

  logic               btn_n;
  logic [N_UNITS-1:0] unit_sel;
  logic [2:0]         mode;
  logic               reload;

  logic [N_UNITS-1:0] unit_en;
  logic [2:0]         atk_type;
  logic               busy;
  logic               err;
  logic               empty;
  logic [SHOT_W-1:0]  shots_left;

  modport master (
    output btn_n, unit_sel, mode, reload,
    input  unit_en, atk_type, busy, err, empty, shots_left
  );

  modport slave (
    input  btn_n, unit_sel, mode, reload,
    output unit_en, atk_type, busy, err, empty, shots_left
  );
endinterface

// File: rtl/attack_enable_ctrl.sv
// Sequential attack-enable controller: synchronised fire button, fixed-length fire pulse,
// cooldown window and a reloadable shot budget gating per-unit enables and type strobes.
//
// state | meaning
// IDLE  | waiting for a press; rejects bad sel/mode with a one-cycle err
// FIRE  | latched unit_en/atk_type driven for PULSE_LEN cycles
// COOL  | outputs low, busy high, presses discarded for COOLDOWN cycles
// LOCK  | shot budget exhausted, empty high until reload
module attack_enable_ctrl #(
  parameter int N_UNITS   = 3,
  parameter int PULSE_LEN = 4,
  parameter int COOLDOWN  = 8,
  parameter int MAX_SHOTS = 5
) (
  input  logic clk,
  input  logic rst,
  attack_if.slave bus
);
  localparam int SHOT_W  = $clog2(MAX_SHOTS + 1);
  localparam int CNT_MAX = (PULSE_LEN > COOLDOWN) ? PULSE_LEN : COOLDOWN;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0]  FIRE_INIT  = CNT_W'(PULSE_LEN - 1);
  localparam logic [CNT_W-1:0]  COOL_INIT  = (COOLDOWN > 0) ? CNT_W'(COOLDOWN - 1) : '0;
  localparam logic [SHOT_W-1:0] SHOTS_FULL = SHOT_W'(MAX_SHOTS);
  localparam logic [SHOT_W-1:0] SHOTS_ONE  = SHOT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FIRE = 2'd1,
    S_COOL = 2'd2,
    S_LOCK = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic               sync1_q, sync1_d;
  logic               sync2_q, sync2_d;
  logic               pressed_q, pressed_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SHOT_W-1:0]  shots_q, shots_d;
  logic [N_UNITS-1:0] sel_q, sel_d;
  logic [2:0]         type_q, type_d;
  logic               err_q, err_d;

  logic pressed;
  logic press;
  logic mode_e, mode_f, mode_g;
  logic mode_ok;
  logic [2:0] type_dec;
  logic accept;

  // Two-flop synchroniser on the raw button; edge detect keeps a held button to one shot.
  always_comb begin
    sync1_d   = bus.btn_n;
    sync2_d   = sync1_q;
    pressed   = ~sync2_q;
    pressed_d = pressed;
    press     = pressed & ~pressed_q;
  end

  always_comb begin
    mode_e   = bus.mode[2];
    mode_f   = bus.mode[1];
    mode_g   = bus.mode[0];
    mode_ok  = (~mode_e & (mode_f | mode_g)) | (mode_e & ~mode_f);
    type_dec = {mode_e & ~mode_f,
                ~mode_e & mode_f,
                mode_g & (~mode_e | ~mode_f)};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shots_d = shots_q;
    sel_d   = sel_q;
    type_d  = type_q;
    err_d   = 1'b0;
    accept  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (press) begin
          if ((|bus.unit_sel) && mode_ok) begin
            accept  = 1'b1;
            sel_d   = bus.unit_sel;
            type_d  = type_dec;
            shots_d = shots_q - SHOTS_ONE;
            cnt_d   = FIRE_INIT;
            state_d = S_FIRE;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      S_FIRE: begin
        if (cnt_q == '0) begin
          if (COOLDOWN > 0) begin
            cnt_d   = COOL_INIT;
            state_d = S_COOL;
          end else begin
            state_d = (shots_q == '0) ? S_LOCK : S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_COOL: begin
        if (cnt_q == '0) begin
          state_d = (shots_q == '0) ? S_LOCK : S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_LOCK: begin
        if (bus.reload) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A reload in the same cycle as an accepted shot still charges that shot.
    if (bus.reload) begin
      shots_d = accept ? (SHOTS_FULL - SHOTS_ONE) : SHOTS_FULL;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      pressed_q <= 1'b0;
      cnt_q     <= '0;
      shots_q   <= SHOTS_FULL;
      sel_q     <= '0;
      type_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      pressed_q <= pressed_d;
      cnt_q     <= cnt_d;
      shots_q   <= shots_d;
      sel_q     <= sel_d;
      type_q    <= type_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    bus.unit_en    = (state_q == S_FIRE) ? sel_q : '0;
    bus.atk_type   = (state_q == S_FIRE) ? type_q : 3'b000;
    bus.busy       = (state_q == S_FIRE) || (state_q == S_COOL);
    bus.empty      = (state_q == S_LOCK);
    bus.err        = err_q;
    bus.shots_left = shots_q;
  end
endmodule

// File: tb/tb_attack_enable_ctrl.sv
// Bench for attack_enable_ctrl: directed scenarios then random traffic, every output
// compared each cycle against a timestamp-based reference model.
module tb_attack_enable_ctrl;
  localparam int NU = 3;
  localparam int PL = 4;
  localparam int CD = 8;
  localparam int MS = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  attack_if #(.N_UNITS(NU), .MAX_SHOTS(MS)) bus ();

  attack_enable_ctrl #(
    .N_UNITS(NU), .PULSE_LEN(PL), .COOLDOWN(CD), .MAX_SHOTS(MS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: time-stamps of the last accepted shot instead of a state machine.
  int      e_now    = 0;
  int      last_acc = 0;
  bit      has_shot = 0;
  bit      locked   = 0;
  int      shots    = MS;
  bit      exp_err  = 0;
  bit [NU-1:0] lat_sel  = '0;
  bit [2:0]    lat_type = '0;
  bit      h1 = 1, h2 = 1, h3 = 1;

  task automatic decode(input logic [2:0] m, output bit ok, output bit [2:0] t);
    case (m)
      3'd1: t = 3'b001;
      3'd2: t = 3'b010;
      3'd3: t = 3'b011;
      3'd4: t = 3'b100;
      3'd5: t = 3'b101;
      default: t = 3'b000;
    endcase
    ok = (m >= 3'd1) && (m <= 3'd5);
  endtask

  task automatic model_edge();
    bit press, ok, acc;
    bit [2:0] t;
    e_now++;
    exp_err = 0;
    if (rst) begin
      has_shot = 0; locked = 0; shots = MS; lat_sel = '0; lat_type = '0;
      h1 = 1; h2 = 1; h3 = 1;
      return;
    end
    press = !h2 && h3;
    acc = 0;
    if (has_shot && e_now == last_acc + PL + CD && shots == 0) begin
      locked = 1;
    end else if (locked) begin
      if (bus.reload) locked = 0;
    end else if ((!has_shot || e_now > last_acc + PL + CD) && press) begin
      decode(bus.mode, ok, t);
      if (ok && bus.unit_sel != '0) begin
        acc = 1; has_shot = 1; last_acc = e_now;
        lat_sel = bus.unit_sel; lat_type = t;
        shots = shots - 1;
      end else begin
        exp_err = 1;
      end
    end
    if (bus.reload) shots = acc ? MS - 1 : MS;
    h3 = h2; h2 = h1; h1 = bus.btn_n;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, e_now, obs, exp);
    end
  endtask

  task automatic check_all();
    bit fire, busy_e;
    fire   = has_shot && (e_now - last_acc) < PL;
    busy_e = has_shot && (e_now - last_acc) < PL + CD;
    chk("unit_en",    32'(bus.unit_en),    fire ? 32'(lat_sel) : 32'd0);
    chk("atk_type",   32'(bus.atk_type),   fire ? 32'(lat_type) : 32'd0);
    chk("busy",       32'(bus.busy),       32'(busy_e));
    chk("err",        32'(bus.err),        32'(exp_err));
    chk("empty",      32'(bus.empty),      32'(locked));
    chk("shots_left", 32'(bus.shots_left), 32'(shots));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic press1(input logic [NU-1:0] s, input logic [2:0] m);
    bus.unit_sel = s;
    bus.mode     = m;
    bus.btn_n    = 1'b0;
    tick();
    bus.btn_n    = 1'b1;
  endtask

  initial begin
    bus.btn_n = 1'b1; bus.unit_sel = '0; bus.mode = 3'b000; bus.reload = 1'b0;
    rst = 1'b1;
    ticks(3);
    rst = 1'b0;
    ticks(4);                                   // idle after reset

    press1(3'b001, 3'b100); ticks(16);          // single unit, type A
    press1(3'b110, 3'b011);                     // B and C together
    bus.unit_sel = 3'b111; bus.mode = 3'b000;   // ignored while firing
    ticks(16);

    press1(3'b001, 3'b000); ticks(4);           // bad mode
    press1(3'b000, 3'b100); ticks(4);           // no unit selected
    press1(3'b010, 3'b111); ticks(4);           // mode 111 rejected

    press1(3'b001, 3'b100); ticks(7);           // press again during cooldown
    press1(3'b100, 3'b010); ticks(16);
    bus.unit_sel = 3'b010; bus.mode = 3'b001; bus.btn_n = 1'b0;
    ticks(30);                                  // held button fires once
    bus.btn_n = 1'b1; ticks(4);

    press1(3'b011, 3'b101); ticks(16);          // last shot, expect lock
    press1(3'b001, 3'b100); ticks(6);           // ignored in lock
    bus.reload = 1'b1; tick(); bus.reload = 1'b0; ticks(2);
    press1(3'b001, 3'b100); ticks(16);

    press1(3'b101, 3'b010); ticks(3);           // reset mid-fire
    rst = 1'b1; tick(); rst = 1'b0; ticks(5);

    bus.unit_sel = 3'b001; bus.mode = 3'b100;   // reload coincident with accept
    bus.btn_n = 1'b0; ticks(2);
    bus.reload = 1'b1; tick(); bus.reload = 1'b0; bus.btn_n = 1'b1;
    ticks(16);

    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 3) == 0) bus.btn_n = ~bus.btn_n;
      bus.unit_sel = NU'($urandom_range(0, (1 << NU) - 1));
      bus.mode     = 3'($urandom_range(0, 7));
      bus.reload   = ($urandom_range(0, 59) == 0);
      tick();
    end
    rst = 1'b0; bus.reload = 1'b0; bus.btn_n = 1'b1;
    ticks(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
